// File: rtl/tournament_predictor.sv
// Tournament branch predictor: a per-PC local-history predictor and a gshare predictor, with a
// per-PC chooser between them. Lookup happens in F, the result is registered into D, and training
// uses branches resolved in M.
module tournament_predictor #(
    parameter int unsigned LHT_IDX_W  = 8,
    parameter int unsigned LHR_W      = 8,
    parameter int unsigned GPHT_IDX_W = 10,
    parameter int unsigned GHR_W      = 8,   // legal range 1..GPHT_IDX_W
    parameter int unsigned CNT_W      = 2    // legal range 2..4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    output logic        predictF,
    output logic        predictD
);

    localparam int unsigned LhtN  = 2 ** LHT_IDX_W;
    localparam int unsigned LphtN = 2 ** LHR_W;
    localparam int unsigned GphtN = 2 ** GPHT_IDX_W;

    typedef logic [LHT_IDX_W-1:0]  lidx_t;
    typedef logic [LHR_W-1:0]      lhr_t;
    typedef logic [GPHT_IDX_W-1:0] gidx_t;
    typedef logic [GHR_W-1:0]      ghr_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    // Weakly not-taken: MSB clear, all lower bits set.
    localparam cnt_t CntInit = {1'b0, {(CNT_W - 1){1'b1}}};

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == {CNT_W{1'b1}}) ? c : c + cnt_t'(1);
    endfunction

    function automatic cnt_t sat_dec(input cnt_t c);
        return (c == '0) ? c : c - cnt_t'(1);
    endfunction

    lhr_t lht_q  [LhtN];
    cnt_t lpht_q [LphtN];
    cnt_t gpht_q [GphtN];
    cnt_t ch_q   [GphtN];
    ghr_t ghr_q, ghr_d;
    logic predict_d_q, predict_d_d;

    // Fetch-side lookup
    lidx_t f_li;
    lhr_t  f_lhr;
    gidx_t f_ci;
    gidx_t f_gi;

    assign f_li  = pcF[LHT_IDX_W+1:2];
    assign f_lhr = lht_q[f_li];
    assign f_ci  = pcF[GPHT_IDX_W+1:2];
    assign f_gi  = f_ci ^ gidx_t'(ghr_q);

    assign predictF = ch_q[f_ci][CNT_W-1] ? gpht_q[f_gi][CNT_W-1] : lpht_q[f_lhr][CNT_W-1];

    // Training side, indexed from the resolved branch against pre-update state
    lidx_t u_li;
    lhr_t  u_lhr;
    gidx_t u_ci;
    gidx_t u_gi;
    logic  u_lp;
    logic  u_gp;

    assign u_li  = update_pc[LHT_IDX_W+1:2];
    assign u_lhr = lht_q[u_li];
    assign u_ci  = update_pc[GPHT_IDX_W+1:2];
    assign u_gi  = u_ci ^ gidx_t'(ghr_q);
    assign u_lp  = lpht_q[u_lhr][CNT_W-1];
    assign u_gp  = gpht_q[u_gi][CNT_W-1];

    lhr_t lht_upd;
    cnt_t lpht_upd;
    cnt_t gpht_upd;
    cnt_t ch_upd;

    always_comb begin
        lpht_upd = update_taken ? sat_inc(lpht_q[u_lhr]) : sat_dec(lpht_q[u_lhr]);
        gpht_upd = update_taken ? sat_inc(gpht_q[u_gi]) : sat_dec(gpht_q[u_gi]);
        ch_upd   = ch_q[u_ci];
        // The chooser only learns when the two components disagree.
        if (u_lp != u_gp) begin
            ch_upd = (u_gp == update_taken) ? sat_inc(ch_q[u_ci]) : sat_dec(ch_q[u_ci]);
        end
        lht_upd = lhr_t'({u_lhr, update_taken});
        ghr_d   = update_en ? ghr_t'({ghr_q, update_taken}) : ghr_q;
    end

    always_comb begin
        predict_d_d = predict_d_q;
        if (flushD) begin
            predict_d_d = 1'b0;
        end else if (!stallD) begin
            predict_d_d = predictF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            predict_d_q <= 1'b0;
            ghr_q       <= '0;
        end else begin
            predict_d_q <= predict_d_d;
            ghr_q       <= ghr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lht_q <= '{default: '0};
        end else if (update_en) begin
            lht_q[u_li] <= lht_upd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lpht_q <= '{default: CntInit};
        end else if (update_en) begin
            lpht_q[u_lhr] <= lpht_upd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpht_q <= '{default: CntInit};
        end else if (update_en) begin
            gpht_q[u_gi] <= gpht_upd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q <= '{default: CntInit};
        end else if (update_en) begin
            ch_q[u_ci] <= ch_upd;
        end
    end

    assign predictD = predict_d_q;

    // Only the index slices of the PCs matter; the rest are intentionally ignored.
    logic unused_pc;
    assign unused_pc = ^{pcF, update_pc};

endmodule

// File: tb/tb_tournament_predictor.sv
// Bench for tournament_predictor: a default and a non-default instance share stimulus and are
// compared against an integer-arithmetic model of the prediction tables.
module tb_tournament_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcF = '0;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic        update_en = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [1:0]  pf;
    logic [1:0]  pd;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tournament_predictor u_dut_def (
        .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .predictF(pf[0]), .predictD(pd[0])
    );

    tournament_predictor #(
        .LHT_IDX_W(8), .LHR_W(8), .GPHT_IDX_W(6), .GHR_W(4), .CNT_W(3)
    ) u_dut_alt (
        .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .predictF(pf[1]), .predictD(pd[1])
    );

    // Reference model configuration per instance
    localparam int C_LIDX [2] = '{8, 8};
    localparam int C_LHR  [2] = '{8, 8};
    localparam int C_GIDX [2] = '{10, 6};
    localparam int C_GHR  [2] = '{8, 4};
    localparam int C_CNT  [2] = '{2, 3};

    int m_lht  [2][256];
    int m_lpht [2][256];
    int m_gpht [2][1024];
    int m_ch   [2][1024];
    int m_ghr  [2];
    bit exp_pd [2];

    function automatic int fld(logic [31:0] pc, int w);
        return int'((pc >> 2) % (32'd1 << w));
    endfunction

    function automatic bit ctaken(int k, int c);
        return c >= (1 << (C_CNT[k] - 1));
    endfunction

    function automatic int bump(int c, bit up, int mx);
        if (up) return (c < mx) ? c + 1 : mx;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic bit m_predict(int k, logic [31:0] pc);
        int lhr = m_lht[k][fld(pc, C_LIDX[k])];
        int ci  = fld(pc, C_GIDX[k]);
        int gi  = ci ^ m_ghr[k];
        return ctaken(k, m_ch[k][ci]) ? ctaken(k, m_gpht[k][gi]) : ctaken(k, m_lpht[k][lhr]);
    endfunction

    task automatic m_reset();
        foreach (m_lht[k, i]) m_lht[k][i] = 0;
        foreach (m_lpht[k, i]) m_lpht[k][i] = (1 << (C_CNT[k] - 1)) - 1;
        foreach (m_gpht[k, i]) m_gpht[k][i] = (1 << (C_CNT[k] - 1)) - 1;
        foreach (m_ch[k, i]) m_ch[k][i] = (1 << (C_CNT[k] - 1)) - 1;
        m_ghr  = '{0, 0};
        exp_pd = '{1'b0, 1'b0};
    endtask

    task automatic m_update(int k, logic [31:0] pc, bit t);
        int mx  = (1 << C_CNT[k]) - 1;
        int li  = fld(pc, C_LIDX[k]);
        int lhr = m_lht[k][li];
        int ci  = fld(pc, C_GIDX[k]);
        int gi  = ci ^ m_ghr[k];
        bit lp  = ctaken(k, m_lpht[k][lhr]);
        bit gp  = ctaken(k, m_gpht[k][gi]);
        if (lp != gp) m_ch[k][ci] = bump(m_ch[k][ci], gp == t, mx);
        m_lpht[k][lhr] = bump(m_lpht[k][lhr], t, mx);
        m_gpht[k][gi]  = bump(m_gpht[k][gi], t, mx);
        m_lht[k][li]   = (lhr * 2 + int'(t)) % (1 << C_LHR[k]);
        m_ghr[k]       = (m_ghr[k] * 2 + int'(t)) % (1 << C_GHR[k]);
    endtask

    // Advance one clock: model the D register and table training, then settle past the edge.
    task automatic step();
        bit nxt [2];
        for (int k = 0; k < 2; k++) begin
            nxt[k] = flushD ? 1'b0 : (!stallD ? m_predict(k, pcF) : exp_pd[k]);
        end
        if (update_en) begin
            for (int k = 0; k < 2; k++) m_update(k, update_pc, update_taken);
        end
        @(posedge clk);
        #1;
        exp_pd = nxt;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        update_en = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
    endtask

    task automatic train(logic [31:0] pc, bit t, int n);
        update_en = 1'b1;
        update_pc = pc;
        update_taken = t;
        repeat (n) step();
        update_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] pcs [3] = '{32'h0, 32'h1000, 32'hBFC0_0000};
        rst = 1'b0;
        m_reset();
        foreach (pcs[i]) begin
            pcF = pcs[i];
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pf[k] !== 1'b0 || pd[k] !== 1'b0)
                    $display("FAIL reset_hold dut%0d pc=%h: got pf=%b pd=%b expected 0/0",
                             k, pcs[i], pf[k], pd[k]);
                else n_pass++;
            end
        end
        rst = 1'b1;
        #1;
        foreach (pcs[i]) begin
            pcF = pcs[i];
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pf[k] !== 1'b0)
                    $display("FAIL reset_pf dut%0d pc=%h: got %b expected 0", k, pcs[i], pf[k]);
                else n_pass++;
            end
            step();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pd[k] !== 1'b0)
                    $display("FAIL reset_pd dut%0d pc=%h: got %b expected 0", k, pcs[i], pd[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_always_taken();
        do_reset();
        pcF = 32'h0;
        train(32'h1000, 1'b1, 10);
        pcF = 32'h1000;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pf[k] !== m_predict(k, pcF))
                $display("FAIL always_taken dut%0d: got %b expected %b", k, pf[k],
                         m_predict(k, pcF));
            else n_pass++;
        end
    endtask

    task automatic test_alternating();
        do_reset();
        pcF = 32'h2000;
        update_en = 1'b1;
        update_pc = 32'h2000;
        for (int i = 0; i < 40; i++) begin
            update_taken = (i % 2 == 0);
            step();
        end
        update_en = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pf[k] !== m_predict(k, pcF))
                $display("FAIL alternating dut%0d: got %b expected %b", k, pf[k],
                         m_predict(k, pcF));
            else n_pass++;
        end
        train(32'h2000, 1'b1, 1);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pf[k] !== m_predict(k, pcF))
                $display("FAIL alternating_extra_t dut%0d: got %b expected %b", k, pf[k],
                         m_predict(k, pcF));
            else n_pass++;
        end
    endtask

    task automatic test_pipeline_reg();
        do_reset();
        pcF = 32'h0;
        train(32'h1000, 1'b1, 10);
        step();
        stallD = 1'b1;
        pcF = 32'h1000;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pf[k] !== m_predict(k, pcF))
                $display("FAIL pipe_pf dut%0d: got %b expected %b", k, pf[k], m_predict(k, pcF));
            else n_pass++;
        end
        repeat (2) begin
            step();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pd[k] !== exp_pd[k])
                    $display("FAIL pipe_stall_hold dut%0d: got %b expected %b", k, pd[k],
                             exp_pd[k]);
                else n_pass++;
            end
        end
        // Let D capture a 1 first so the flush has something to clear.
        stallD = 1'b0;
        step();
        stallD = 1'b1;
        flushD = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pd[k] !== 1'b0)
                $display("FAIL pipe_flush dut%0d: got %b expected 0", k, pd[k]);
            else n_pass++;
        end
        stallD = 1'b0;
        flushD = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pd[k] !== exp_pd[k])
                $display("FAIL pipe_follow dut%0d: got %b expected %b", k, pd[k], exp_pd[k]);
            else n_pass++;
        end
    endtask

    task automatic test_same_cycle_hazard();
        do_reset();
        pcF = 32'h0;
        train(32'h3000, 1'b1, 8);
        pcF = 32'h3000;
        update_en = 1'b1;
        update_pc = 32'h3000;
        update_taken = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pf[k] !== m_predict(k, pcF))
                $display("FAIL hazard_same_cycle dut%0d: got %b expected %b", k, pf[k],
                         m_predict(k, pcF));
            else n_pass++;
        end
        step();
        update_en = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pf[k] !== m_predict(k, pcF))
                $display("FAIL hazard_next_cycle dut%0d: got %b expected %b", k, pf[k],
                         m_predict(k, pcF));
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        pcF = 32'h0;
        train(32'h1000, 1'b1, 10);
        pcF = 32'h1000;
        step();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pd[k] !== exp_pd[k])
                $display("FAIL async_pre_pd dut%0d: got %b expected %b", k, pd[k], exp_pd[k]);
            else n_pass++;
        end
        #2 rst = 1'b0;
        #1;
        m_reset();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pd[k] !== 1'b0 || pf[k] !== 1'b0)
                $display("FAIL async_reset dut%0d: got pd=%b pf=%b expected 0/0", k, pd[k],
                         pf[k]);
            else n_pass++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pf[k] !== 1'b0)
                $display("FAIL async_post_pf dut%0d: got %b expected 0", k, pf[k]);
            else n_pass++;
        end
    endtask

    task automatic test_nondefault();
        do_reset();
        pcF = 32'h4000;
        #1;
        n_checks++;
        if (pf[1] !== 1'b0) $display("FAIL nondef_init: got %b expected 0", pf[1]);
        else n_pass++;
        train(32'h4000, 1'b1, 12);
        #1;
        n_checks++;
        if (pf[1] !== 1'b1) $display("FAIL nondef_12_taken: got %b expected 1", pf[1]);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pf[k] !== m_predict(k, pcF))
                $display("FAIL nondef_model dut%0d: got %b expected %b", k, pf[k],
                         m_predict(k, pcF));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        // Includes aliasing PCs (same low index bits) and an outlier.
        logic [31:0] pool [6] = '{32'h1000, 32'h1400, 32'h2004, 32'h1000_1000, 32'h3008,
                                  32'hBFC0_0010};
        do_reset();
        for (int c = 0; c < 600; c++) begin
            pcF          = pool[$urandom_range(5)];
            update_pc    = pool[$urandom_range(5)];
            update_en    = ($urandom_range(3) != 0);
            update_taken = ($urandom_range(3) != 0) ^ update_pc[4];
            stallD       = ($urandom_range(4) == 0);
            flushD       = ($urandom_range(8) == 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pf[k] !== m_predict(k, pcF))
                    $display("FAIL random_pf dut%0d cyc=%0d: got %b expected %b", k, c, pf[k],
                             m_predict(k, pcF));
                else n_pass++;
            end
            step();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pd[k] !== exp_pd[k])
                    $display("FAIL random_pd dut%0d cyc=%0d: got %b expected %b", k, c, pd[k],
                             exp_pd[k]);
                else n_pass++;
            end
        end
        update_en = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b0;
        test_reset();
        test_always_taken();
        test_alternating();
        test_pipeline_reg();
        test_same_cycle_hazard();
        test_async_reset();
        test_nondefault();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
